pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the fetch buffer entry count; only the value 2 is supported.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 SHALL have port redirect_valid, input, 1 bit, which asserts that redirect_pc replaces the sequential PC (any is_jal/is_jlr/is_beq/is_R7_pc taken).
REQ-006 SHALL have port redirect_pc, input, 16 bits, the redirect target from the PC priority select.
REQ-007 SHALL have port imem_req_valid, output, 1 bit, the instruction-memory request.
REQ-008 SHALL have port imem_req_ready, input, 1 bit; the memory accepts the request when both are high.
REQ-009 SHALL have port imem_addr, output, 16 bits, the request address; stable while imem_req_valid is high and not accepted.
REQ-010 SHALL have port imem_rsp_valid, input, 1 bit, the one-cycle response strobe (no backpressure).
REQ-011 SHALL have port imem_rsp_data, input, 16 bits, the fetched instruction word.
REQ-012 SHALL have port if_valid, output, 1 bit; the buffer head is valid toward decode.
REQ-013 SHALL have port if_ready, input, 1 bit; decode consumes the head when if_valid and if_ready are both high.
REQ-014 SHALL have ports if_instr, if_pc and if_pc_p1, outputs, 16 bits each, carrying the head instruction, its address and address+1; if_pc_p1 feeds the pc_p1 input of the priority select.

Function
REQ-015 SHALL keep at most one outstanding imem request, with FSM states REQ (may issue), WAIT (one outstanding) and DISCARD (one outstanding, response to be dropped).
REQ-016 SHALL, in REQ, drive imem_req_valid=1 iff buffer count < 2 and redirect_valid=0, with imem_addr=fetch_pc.
REQ-017 SHALL move REQ->WAIT on request acceptance, recording req_pc=fetch_pc.
REQ-018 SHALL, in WAIT on imem_rsp_valid, push {req_pc, imem_rsp_data}, set fetch_pc=req_pc+1 (16-bit wrap, 16'hFFFF->16'h0000) and go to REQ.
REQ-019 SHALL, on redirect_valid, flush the buffer (count=0, if_valid=0 next cycle) and load fetch_pc=redirect_pc.
REQ-020 SHALL, on a redirect while in WAIT (response not arriving the same cycle), go to DISCARD; in all other redirect cases go to REQ.
REQ-021 SHALL, in DISCARD, drop the next imem_rsp_valid response without pushing it, then go to REQ; a further redirect while in DISCARD only reloads fetch_pc.
REQ-022 SHALL give redirect priority over a same-cycle response: that response is dropped and the FSM goes to REQ.
REQ-023 SHALL support push and pop in the same cycle, leaving the count unchanged; with a full buffer, no request is issued.
REQ-024 SHALL give a first-response-to-if_valid latency of 1 cycle (registered buffer); a pop on a flush cycle is ignored.

Reset
REQ-025 SHALL, while rst=1, set: state=REQ, fetch_pc=RESET_PC, buffer count=0, imem_req_valid=0, if_valid=0, if_instr/if_pc/if_pc_p1=0, perf counters=0.
REQ-026 SHALL discard any response returning after reset deasserts if it belongs to a request issued before reset.

Configuration
REQ-027 SHALL, with macro FETCH_PERF_EN defined, provide 16-bit saturating outputs perf_redirect_cnt (redirect cycles) and perf_discard_cnt (dropped responses).
REQ-028 SHALL, without FETCH_PERF_EN, keep those ports present but tie them to 0 with no counter flops.

Structure
REQ-029 SHALL place the FSM state enum, the XLEN=16 constant and the RESET_PC default in the shared package fetch_pkg.
REQ-030 SHALL implement the 2-entry FIFO (push, pop, flush, count, head) as sub-module fetch_buffer.

Verification
REQ-031 SHALL cover: reset, memory always ready, 1-cycle response latency, if_ready=1 -> addresses 0,1,2,3 requested in order, and if_pc/if_instr match each returned word.
REQ-032 SHALL cover: if_ready=0 -> exactly 2 entries buffered, imem_req_valid=0, then if_ready=1 drains 0 then 1 and fetch resumes at 2.
REQ-033 SHALL cover: redirect to 16'h0040 while in WAIT -> response dropped, perf_discard_cnt=1, next request address 16'h0040.
REQ-034 SHALL cover: redirect and imem_rsp_valid in the same cycle -> no push, next imem_addr=redirect_pc, if_valid=0.
REQ-035 SHALL cover: redirect to 16'hFFFF -> fetches at 16'hFFFF then 16'h0000, with if_pc_p1=16'h0000 for the first.
REQ-036 SHALL cover: rst asserted mid-WAIT -> outputs 0 immediately, then first request at RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg -- shared constants, FSM state encodings and buffer entry type
// Rev 1.0
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 16;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  // Fetch FSM: REQ may issue, WAIT has one live request,
  // DISCARD has one request whose response must be dropped.
  localparam logic [1:0] ST_REQ     = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_buffer -- 2-entry registered FIFO with flush; head visible one cycle after push
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  // A pop on a flush cycle or on an empty buffer has no effect.
  assign do_pop     = pop && (count != 2'd0) && !flush;
  assign head_valid = (count != 2'd0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_fetch_unit -- single-outstanding instruction fetch with 2-entry buffer;
// optional perf counters under FETCH_PERF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_p1,
  output logic [15:0]     perf_redirect_cnt,
  output logic [15:0]     perf_discard_cnt
);

  logic [1:0]      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [1:0]      buf_count;
  logic            head_valid;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            req_fire;
  logic            push;

  // Gated by rst so the request is low during reset even though state is REQ.
  assign imem_req_valid = !rst && (state == ST_REQ) && (buf_count < 2'(BUF_DEPTH))
                          && !redirect_valid;
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
  assign push_entry     = '{pc: req_pc, instr: imem_rsp_data};

  // Responses seen in REQ (e.g. from a request issued before reset) are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      state    <= ((state != ST_REQ) && !imem_rsp_valid) ? ST_DISCARD : ST_REQ;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_fire) begin
            req_pc <= fetch_pc;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            fetch_pc <= req_pc + XLEN'(1);
            state    <= ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (imem_rsp_valid) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (if_ready),
    .head       (head),
    .head_valid (head_valid),
    .count      (buf_count)
  );

  assign if_valid = head_valid;
  assign if_instr = head_valid ? head.instr : '0;
  assign if_pc    = head_valid ? head.pc : '0;
  assign if_pc_p1 = head_valid ? head.pc + XLEN'(1) : '0;

`ifdef FETCH_PERF_EN
  logic        rsp_dropped;
  logic [15:0] redirect_cnt;
  logic [15:0] discard_cnt;

  assign rsp_dropped = imem_rsp_valid && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt <= 16'd0;
      discard_cnt  <= 16'd0;
    end else begin
      if (redirect_valid && (redirect_cnt != 16'hFFFF)) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
      if (rsp_dropped && (discard_cnt != 16'hFFFF)) begin
        discard_cnt <= discard_cnt + 16'd1;
      end
    end
  end

  assign perf_redirect_cnt = redirect_cnt;
  assign perf_discard_cnt  = discard_cnt;
`else
  assign perf_redirect_cnt = 16'd0;
  assign perf_discard_cnt  = 16'd0;
`endif

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// tb_pc_fetch_unit -- directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the fetch unit and a latency-programmable memory.
module tb_pc_fetch_unit;

  localparam logic [15:0] RESET_PC_TB = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = 16'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_p1;
  logic [15:0] perf_redirect_cnt;
  logic [15:0] perf_discard_cnt;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RESET_PC_TB), .BUF_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_addr         (imem_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .if_pc_p1          (if_pc_p1),
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_discard_cnt  (perf_discard_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, instr}, outstanding status, next fetch address.
  logic [31:0] q[$];
  int          m_out;          // 0 none, 1 live request, 2 stale request
  logic [15:0] m_fetch;
  logic [15:0] m_req;
  int          m_redir;
  int          m_disc;

  // Memory model
  bit          mem_pend = 0;
  int          mem_left = 0;
  logic [15:0] mem_a = 16'h0;
  int          lat = 1;

  // Observation logs
  logic [15:0] acc_q[$];
  logic [15:0] pop_q[$];
  bit          ffff_seen = 0;
  logic [15:0] ffff_p1 = 16'h1234;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  function automatic logic [31:0] exp_perf(input int v);
`ifdef FETCH_PERF_EN
    return (v > 65535) ? 32'd65535 : 32'(v);
`else
    return (v > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_out   = 0;
    m_fetch = RESET_PC_TB;
    m_req   = RESET_PC_TB;
    m_redir = 0;
    m_disc  = 0;
  endtask

  // rmode: 0 = rst low, 1 = rst held high, 2 = rst asserted mid-cycle
  task automatic cycle(input bit rd, input logic [15:0] rpc, input bit ir, input bit rdy,
                       input int rmode);
    bit          exp_req;
    bit          acc;
    bit          rsp;
    bit          pushed;
    bit          popped;
    logic [15:0] p1;
    logic [15:0] acc_addr;
    @(negedge clk);
    rst            = (rmode == 1);
    redirect_valid = rd;
    redirect_pc    = rpc;
    if_ready       = ir;
    imem_req_ready = rdy;
    imem_rsp_valid = mem_pend && (mem_left == 0);
    imem_rsp_data  = mem_pend ? mem_word(mem_a) : 16'hDEAD;
    #1;
    if (rmode == 2) begin
      rst = 1'b1;
      #1;
    end
    rsp     = imem_rsp_valid;
    exp_req = 1'b0;
    if (rst) begin
      model_reset();
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_instr", {16'd0, if_instr}, 32'd0);
      check("rst_if_pc", {16'd0, if_pc}, 32'd0);
      check("rst_if_pc_p1", {16'd0, if_pc_p1}, 32'd0);
      check("rst_perf_redir", {16'd0, perf_redirect_cnt}, 32'd0);
      check("rst_perf_disc", {16'd0, perf_discard_cnt}, 32'd0);
    end else begin
      exp_req = (m_out == 0) && (q.size() < 2) && !rd;
      check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      if (exp_req) check("req_addr", {16'd0, imem_addr}, {16'd0, m_fetch});
      check("if_valid", {31'd0, if_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
      if (q.size() > 0) begin
        p1 = q[0][31:16] + 16'd1;
        check("if_pc", {16'd0, if_pc}, {16'd0, q[0][31:16]});
        check("if_instr", {16'd0, if_instr}, {16'd0, q[0][15:0]});
        check("if_pc_p1", {16'd0, if_pc_p1}, {16'd0, p1});
      end
      check("perf_redir", {16'd0, perf_redirect_cnt}, exp_perf(m_redir));
      check("perf_disc", {16'd0, perf_discard_cnt}, exp_perf(m_disc));
      if (imem_req_valid && rdy) acc_q.push_back(imem_addr);
      if (if_valid && ir && !rd) pop_q.push_back(if_pc);
      if (if_valid && (if_pc == 16'hFFFF)) begin
        ffff_seen = 1;
        ffff_p1   = if_pc_p1;
      end
    end
    @(posedge clk);
    acc      = exp_req && rdy;
    acc_addr = m_fetch;
    if (!rst) begin
      pushed = rsp && (m_out == 1) && !rd;
      popped = ir && (q.size() > 0) && !rd;
      if (rd) m_redir++;
      if (rsp && !pushed) m_disc++;
      if (rd) begin
        q.delete();
        m_out   = (m_out != 0 && !rsp) ? 2 : 0;
        m_fetch = rpc;
      end else begin
        if (popped) void'(q.pop_front());
        if (pushed) begin
          q.push_back({m_req, imem_rsp_data});
          m_fetch = m_req + 16'd1;
          m_out   = 0;
        end else if (rsp && m_out == 2) begin
          m_out = 0;
        end
        if (acc) begin
          m_out = 1;
          m_req = acc_addr;
        end
      end
    end
    if (mem_pend) begin
      if (mem_left == 0) mem_pend = 0;
      else mem_left--;
    end
    if (acc) begin
      mem_pend = 1;
      mem_left = lat - 1;
      mem_a    = acc_addr;
    end
  endtask

  task automatic hold_reset();
    repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1);
    acc_q.delete();
    pop_q.delete();
  endtask

  initial begin
    model_reset();

    // Sequential fetch with always-ready memory, 1-cycle latency
    lat = 1;
    hold_reset();
    repeat (10) cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    check("s1_n_acc", (acc_q.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) check("s1_addr", {16'd0, acc_q[i]}, 32'(i));
    for (int i = 0; i < 3 && i < pop_q.size(); i++) check("s1_pop_pc", {16'd0, pop_q[i]}, 32'(i));

    // Decode stalled: buffer fills, requests stop, then drains in order
    hold_reset();
    repeat (10) cycle(1'b0, 16'h0, 1'b0, 1'b1, 0);
    check("s2_n_acc", 32'(acc_q.size()), 32'd2);
    #1;
    check("s2_req_idle", {31'd0, imem_req_valid}, 32'd0);
    check("s2_if_valid", {31'd0, if_valid}, 32'd1);
    acc_q.delete();
    pop_q.delete();
    repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    check("s2_drain0", (pop_q.size() > 0) ? {16'd0, pop_q[0]} : 32'hFFFF_FFFF, 32'd0);
    check("s2_drain1", (pop_q.size() > 1) ? {16'd0, pop_q[1]} : 32'hFFFF_FFFF, 32'd1);
    check("s2_resume", (acc_q.size() > 0) ? {16'd0, acc_q[0]} : 32'hFFFF_FFFF, 32'd2);

    // Redirect while WAIT: in-flight response dropped
    hold_reset();
    lat = 2;
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    cycle(1'b1, 16'h0040, 1'b1, 1'b1, 0);
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    #1;
    check("s3_disc_cnt", {16'd0, perf_discard_cnt}, exp_perf(1));
    check("s3_if_valid", {31'd0, if_valid}, 32'd0);
    acc_q.delete();
    repeat (3) cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    check("s3_redir_addr", (acc_q.size() > 0) ? {16'd0, acc_q[0]} : 32'hFFFF_FFFF, 32'h40);

    // Redirect and response in the same cycle
    hold_reset();
    lat = 1;
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    cycle(1'b1, 16'h0123, 1'b1, 1'b1, 0);
    #1;
    check("s4_if_valid", {31'd0, if_valid}, 32'd0);
    acc_q.delete();
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    check("s4_redir_addr", (acc_q.size() > 0) ? {16'd0, acc_q[0]} : 32'hFFFF_FFFF, 32'h123);

    // Redirect to the top of the address space: wrap to 0
    hold_reset();
    ffff_seen = 0;
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b1, 0);
    acc_q.delete();
    repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    check("s5_addr0", (acc_q.size() > 0) ? {16'd0, acc_q[0]} : 32'hFFFF_FFFF, 32'hFFFF);
    check("s5_addr1", (acc_q.size() > 1) ? {16'd0, acc_q[1]} : 32'hFFFF_FFFF, 32'h0);
    check("s5_seen", {31'd0, ffff_seen}, 32'd1);
    check("s5_p1", {16'd0, ffff_p1}, 32'h0);

    // Reset mid-WAIT with a valid head; stale response arrives after release
    hold_reset();
    lat = 1;
    repeat (2) cycle(1'b0, 16'h0, 1'b0, 1'b1, 0);
    lat = 2;
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 2);
    lat = 1;
    acc_q.delete();
    pop_q.delete();
    repeat (4) cycle(1'b0, 16'h0, 1'b1, 1'b1, 0);
    check("s6_first_addr", (acc_q.size() > 0) ? {16'd0, acc_q[0]} : 32'hFFFF_FFFF,
          {16'd0, RESET_PC_TB});
    check("s6_first_pop", (pop_q.size() > 0) ? {16'd0, pop_q[0]} : 32'hFFFF_FFFF,
          {16'd0, RESET_PC_TB});

    // Random traffic
    hold_reset();
    for (int n = 0; n < 800; n++) begin
      bit          rd;
      logic [15:0] rpc;
      lat = int'($urandom_range(1, 3));
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      cycle(rd, rpc, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
